// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared constants for the parametrised up/down counter primitive.
//   MODE_WRAP / MODE_SAT : behaviour at the terminal values (0 and MAX)
//   DIR_UP / DIR_DOWN    : encoding of the updown input
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    localparam bit DIR_UP    = 1'b1;
    localparam bit DIR_DOWN  = 1'b0;

endpackage : counter_pkg

// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
// General-purpose load / up-down counter with programmable modulus (MAX),
// count enable, wrap-or-saturate terminal behaviour, terminal-count flag,
// a one-cycle boundary-event pulse and sticky overflow/underflow flags.
//
// Parameters
//   WIDTH   : counter width in bits (2..32)
//   MAX     : highest count value, 1..2**WIDTH-1; q stays within 0..MAX
//   MODE    : MODE_WRAP (modulo MAX+1) or MODE_SAT (hold at 0 / MAX)
//   RST_VAL : value of q after reset, must not exceed MAX
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : asynchronous active-low reset
//   en        : count enable
//   load      : synchronous parallel load, takes priority over en
//   updown    : direction, 1 = up, 0 = down
//   d         : load value (values above MAX clamp to MAX)
//   clr_flags : synchronous clear of ovf/udf
//   q         : registered count
//   tc        : combinational terminal count for the current direction
//   evt       : registered pulse, last enabled step hit a boundary
//   ovf       : sticky, up-step attempted at q == MAX
//   udf       : sticky, down-step attempted at q == 0
// -----------------------------------------------------------------------------
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX     = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                                   : ((32'd1 << WIDTH) - 32'd1),
    parameter bit          MODE    = MODE_WRAP,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             updown,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             evt,
    output logic             ovf,
    output logic             udf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 2 || WIDTH > 32) begin : g_chk_width
        $error("updown_counter_param: WIDTH must be in 2..32");
    end
    if (MAX < 1 || (WIDTH < 32 && MAX > ((32'd1 << WIDTH) - 32'd1))) begin : g_chk_max
        $error("updown_counter_param: MAX must be in 1..2**WIDTH-1");
    end
    if (RST_VAL > MAX) begin : g_chk_rst_val
        $error("updown_counter_param: RST_VAL must not exceed MAX");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             evt_q,   evt_d;
    logic             ovf_q,   ovf_d;
    logic             udf_q,   udf_d;

    logic             at_max;
    logic             at_zero;

    // Load values above the modulus are pulled back into range so q can
    // never leave 0..MAX.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
        return (val > MAX_V) ? MAX_V : val;
    endfunction

    // Boundary is detected before stepping, so no carry/borrow bit is needed
    // and a non-power-of-two MAX wraps cleanly.
    function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] cur,
                                                    input logic             dir);
        logic [WIDTH-1:0] nxt;
        nxt = cur;
        if (dir == DIR_UP) begin
            if (cur == MAX_V) begin
                nxt = (MODE == MODE_SAT) ? MAX_V : '0;
            end else begin
                nxt = cur + WIDTH'(1);
            end
        end else begin
            if (cur == '0) begin
                nxt = (MODE == MODE_SAT) ? '0 : MAX_V;
            end else begin
                nxt = cur - WIDTH'(1);
            end
        end
        return nxt;
    endfunction

    assign at_max  = (count_q == MAX_V);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        evt_d   = 1'b0;
        // A boundary event below overrides the clear, so a same-edge event
        // still leaves the flag set.
        ovf_d   = ovf_q & ~clr_flags;
        udf_d   = udf_q & ~clr_flags;

        if (load) begin
            count_d = clamp_load(d);
        end else if (en) begin
            count_d = step_value(count_q, updown);
            if ((updown == DIR_UP) && at_max) begin
                evt_d = 1'b1;
                ovf_d = 1'b1;
            end else if ((updown == DIR_DOWN) && at_zero) begin
                evt_d = 1'b1;
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RST_V;
            evt_q   <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            evt_q   <= evt_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign q   = count_q;
    assign evt = evt_q;
    assign ovf = ovf_q;
    assign udf = udf_q;

    // Terminal count looks at the live direction so it flips with updown
    // without waiting for a clock edge.
    assign tc  = ((updown == DIR_UP) && at_max) || ((updown == DIR_DOWN) && at_zero);

endmodule : updown_counter_param

// File: tb/tb_updown_counter_param.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_param
// Three counter instances share one stimulus bus:
//   unit 0 : WIDTH=8, MAX=255, WRAP, RST_VAL=5
//   unit 1 : WIDTH=4, MAX=9,   WRAP (decade digit)
//   unit 2 : WIDTH=8, MAX=255, SAT
// The driver pushes hand-computed expectations (tagged with the cycle they
// become visible) into a queue; an independent monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_updown_counter_param;
    import counter_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic       updown;
    logic [7:0] d;
    logic       clr_flags;

    logic [7:0] q0, q2;
    logic [3:0] q1;
    logic       tc0, tc1, tc2;
    logic       evt0, evt1, evt2;
    logic       ovf0, ovf1, ovf2;
    logic       udf0, udf1, udf2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         due;
        int         unit;
        logic [7:0] q;
        logic       tc;
        logic       evt;
        logic       ovf;
        logic       udf;
        string      tag;
    } exp_t;

    exp_t sb[$];

    updown_counter_param #(.WIDTH(8), .MAX(255), .MODE(MODE_WRAP), .RST_VAL(5)) u_cnt0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .updown(updown), .d(d),
        .clr_flags(clr_flags), .q(q0), .tc(tc0), .evt(evt0), .ovf(ovf0), .udf(udf0)
    );

    updown_counter_param #(.WIDTH(4), .MAX(9), .MODE(MODE_WRAP), .RST_VAL(0)) u_cnt1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .updown(updown), .d(d[3:0]),
        .clr_flags(clr_flags), .q(q1), .tc(tc1), .evt(evt1), .ovf(ovf1), .udf(udf1)
    );

    updown_counter_param #(.WIDTH(8), .MAX(255), .MODE(MODE_SAT), .RST_VAL(0)) u_cnt2 (
        .clk(clk), .rst(rst), .en(en), .load(load), .updown(updown), .d(d),
        .clr_flags(clr_flags), .q(q2), .tc(tc2), .evt(evt2), .ovf(ovf2), .udf(udf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge, half a cycle before they are sampled.
    task automatic step(input logic r, input logic ld, input logic e, input logic ud,
                        input logic [7:0] dv, input logic cf);
        @(negedge clk);
        rst       = r;
        load      = ld;
        en        = e;
        updown    = ud;
        d         = dv;
        clr_flags = cf;
    endtask

    // Expected outputs of one unit just after the next rising edge.
    task automatic expect_out(input int unit, input logic [7:0] eq, input logic etc,
                              input logic eevt, input logic eovf, input logic eudf,
                              input string tag);
        exp_t e;
        e.due  = cyc + 1;
        e.unit = unit;
        e.q    = eq;
        e.tc   = etc;
        e.evt  = eevt;
        e.ovf  = eovf;
        e.udf  = eudf;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t       e;
            logic [7:0] aq;
            logic       atc, aevt, aovf, audf;
            e = sb.pop_front();
            case (e.unit)
                0:       begin aq = q0;          atc = tc0; aevt = evt0; aovf = ovf0; audf = udf0; end
                1:       begin aq = {4'h0, q1};  atc = tc1; aevt = evt1; aovf = ovf1; audf = udf1; end
                default: begin aq = q2;          atc = tc2; aevt = evt2; aovf = ovf2; audf = udf2; end
            endcase
            checks = checks + 1;
            if (e.due != cyc || {aq, atc, aevt, aovf, audf} !== {e.q, e.tc, e.evt, e.ovf, e.udf}) begin
                errors = errors + 1;
                $display("FAIL %s (unit %0d, cycle %0d): got q=%0h tc=%b evt=%b ovf=%b udf=%b, want q=%0h tc=%b evt=%b ovf=%b udf=%b",
                         e.tag, e.unit, cyc, aq, atc, aevt, aovf, audf,
                         e.q, e.tc, e.evt, e.ovf, e.udf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // Decade count up from 0, twelve steps.
    logic [3:0] dec_q   [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic       dec_evt [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic       dec_ovf [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic       dec_tc  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

    initial begin
        rst = 1'b0; load = 1'b0; en = 1'b0; updown = 1'b1; d = 8'h00; clr_flags = 1'b0;

        // ---- unit 0: reset value, wrap at 255, reset mid-count, load ----
        step(0, 0, 1, 1, 8'h00, 0); expect_out(0, 8'h05, 0, 0, 0, 0, "rst_hold");
        step(1, 0, 1, 1, 8'h00, 0); expect_out(0, 8'h06, 0, 0, 0, 0, "rst_release_count");
        step(1, 1, 0, 1, 8'hFF, 0); expect_out(0, 8'hFF, 1, 0, 0, 0, "load_ff_tc");
        step(1, 0, 1, 1, 8'h00, 0); expect_out(0, 8'h00, 0, 1, 1, 0, "binary_wrap");
        step(1, 0, 1, 1, 8'h00, 0); expect_out(0, 8'h01, 0, 0, 1, 0, "ovf_sticky");
        step(0, 0, 1, 1, 8'h00, 0); expect_out(0, 8'h05, 0, 0, 0, 0, "rst_mid_count");
        step(1, 1, 1, 1, 8'h3C, 0); expect_out(0, 8'h3C, 0, 0, 0, 0, "load_3c");

        // ---- unit 1: decade counter ----
        step(1, 1, 0, 1, 8'h00, 0); expect_out(1, 8'h00, 0, 0, 0, 0, "dec_load0");
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 1, 1, 8'h00, 0);
            expect_out(1, {4'h0, dec_q[i]}, dec_tc[i], dec_evt[i], dec_ovf[i], 0, "dec_up");
        end
        step(1, 1, 0, 0, 8'h00, 0); expect_out(1, 8'h00, 1, 0, 1, 0, "dec_load0_down_tc");
        step(1, 0, 1, 0, 8'h00, 0); expect_out(1, 8'h09, 0, 1, 1, 1, "dec_down_wrap");
        step(1, 0, 0, 0, 8'h00, 1); expect_out(1, 8'h09, 0, 0, 0, 0, "dec_clr_flags");
        step(1, 0, 1, 1, 8'h00, 0); expect_out(1, 8'h00, 0, 1, 1, 0, "dec_turnaround_wrap");
        step(1, 1, 1, 1, 8'h0C, 0); expect_out(1, 8'h09, 1, 0, 1, 0, "dec_load_clamp_prio");
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, 8'h00, 0);
            expect_out(1, 8'h09, 1, 0, 1, 0, "dec_hold");
        end
        step(1, 0, 1, 1, 8'h00, 1); expect_out(1, 8'h00, 0, 1, 1, 0, "dec_flag_race");
        step(1, 0, 0, 1, 8'h00, 1); expect_out(1, 8'h00, 0, 0, 0, 0, "dec_clr_after_race");

        // ---- unit 2: saturating counter ----
        step(1, 1, 0, 1, 8'hFE, 1); expect_out(2, 8'hFE, 0, 0, 0, 0, "sat_load_fe");
        step(1, 0, 1, 1, 8'h00, 0); expect_out(2, 8'hFF, 1, 0, 0, 0, "sat_up1");
        step(1, 0, 1, 1, 8'h00, 0); expect_out(2, 8'hFF, 1, 1, 1, 0, "sat_up2");
        step(1, 0, 1, 1, 8'h00, 0); expect_out(2, 8'hFF, 1, 1, 1, 0, "sat_up3");
        step(1, 1, 0, 0, 8'h00, 0); expect_out(2, 8'h00, 1, 0, 1, 0, "sat_load0_down");
        step(1, 0, 1, 0, 8'h00, 0); expect_out(2, 8'h00, 1, 1, 1, 1, "sat_down_hold");

        step(1, 0, 0, 1, 8'h00, 0);
        repeat (2) @(posedge clk);
        #2;
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_updown_counter_param
